data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
// Direct-mapped, write-through, no-write-allocate L1 data cache. Sits between the
// data path load/store port (ALUResult address, ReadData2 store data, MemWrite) and a
// multi-cycle backing memory. It stalls the core on misses and on all stores.
// Provides RISC-V byte/half/word load extraction and store lane steering.
// PARAMETERS
// IDX_BITS   6   index width; SETS = 2**IDX_BITS one-word (32-bit) lines
// PORTS
// clk                in   1   clock, all state updates on rising edge
// rst                in   1   synchronous, active-high reset
// RE                 in   1   load request
// WE                 in   1   store request (priority over RE)
// A                  in   32  byte address from ALU
// WD                 in   32  store data, low-aligned
// AddressingControl  in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// RD                 out  32  load result, extended
// Stall              out  1   core must hold PC and all request inputs while high
// mem_req            out  1   backing-memory request valid
// mem_we             out  1   1 = write, 0 = read
// mem_addr           out  32  word address {A[31:2],2'b00}
// mem_wdata          out  32  lane-steered store data
// mem_wstrb          out  4   byte enables; 0000 on reads
// mem_rdata          in   32  read data, valid when mem_ready is high
// mem_ready          in   1   one-cycle completion pulse; ignored when mem_req is low
// hit_count          out  32  saturating count of load hits
// miss_count         out  32  saturating count of load misses
// BEHAVIOUR
// - index = A[IDX_BITS+1:2], tag = A[31:IDX_BITS+2]; hit = valid[index] && tag match.
// - Reset: all valid bits cleared, state IDLE, ack = 0, Stall = 0, mem_req = 0,
//   mem_we = 0, mem_wstrb = 0, counters = 0, RD = 0. Reset mid-FILL or mid-WRITE
//   abandons the transaction. mem_req is low the cycle after rst. No line is written.
// - FSM states: IDLE, FILL, WRITE.
//   IDLE:  WE && !ack -> WRITE.  RE && !WE && !hit -> FILL. Otherwise stay.
//   FILL:  mem_req = 1, mem_we = 0. When mem_ready: line <= mem_rdata, set valid,
//          set tag, go to IDLE.
//   WRITE: mem_req = 1, mem_we = 1. When mem_ready: if hit, merge the strobed bytes
//          into the line. Set ack = 1 and go to IDLE.
// - ack is high for exactly one cycle after WRITE ends. In IDLE with ack, the pending
//   store completes with Stall = 0 and no new request is issued.
// - Stall (combinational) = (state != IDLE) || (IDLE && WE && !ack) ||
//   (IDLE && RE && !WE && !hit).
// - Read hit latency is 0: RD is valid in the same cycle and Stall = 0.
// - Read miss cost is fill cycles + 1: the cycle after mem_ready is a hit in IDLE.
// - RD extraction from the line word:
//   B/BU: byte at A[1:0]. H/HU: halfword at A[1] (A[0] ignored). W: whole word
//   (A[1:0] ignored). B and H are sign-extended; BU and HU are zero-extended.
//   Undefined codes load as W. RD = 0 when no load is in progress.
// - Stores:
//   SB: mem_wstrb = 1<<A[1:0], mem_wdata = {4{WD[7:0]}}.
//   SH: mem_wstrb = A[1] ? 1100 : 0011, mem_wdata = {2{WD[15:0]}}.
//   SW and undefined codes: mem_wstrb = 1111, mem_wdata = WD.
// - No write allocate: a store miss leaves the valid and tag bits unchanged.
// - RE && WE together is treated as a store only.
// - mem_addr, mem_wdata and mem_wstrb are held stable while mem_req is high.
// - miss_count increments on the IDLE->FILL transition. hit_count increments on an
//   IDLE load with hit, excluding the first cycle after a FILL. Both counters saturate
//   at 32'hFFFF_FFFF.
// TESTING
// - Reset, then LW at 0x100. Stall is high, mem_req high, mem_addr 0x100. mem_rdata
//   0xDEADBEEF with mem_ready after 3 cycles. The next cycle gives RD = 0xDEADBEEF,
//   Stall = 0 and miss_count = 1.
// - Repeat LW at 0x100. RD = 0xDEADBEEF in the same cycle, no mem_req, hit_count = 1.
// - LB, LBU, LH and LHU at 0x103 and 0x102 on the cached 0xDEADBEEF. Expected RD:
//   0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD and 0x0000DEAD.
// - SB 0x5A at 0x101 (hit). Expect mem_wstrb 0010, mem_wdata 0x5A5A5A5A, Stall until
//   the ack cycle, exactly one mem_req. A following LW at 0x100 returns 0xDEAD5AEF.
// - SW at 0x200 (miss). Exactly one write is issued, and a following LW at 0x200 misses
//   (no allocate). Also test RE = WE = 1: it is treated as a store, not a fill.
// - Assert rst during FILL before mem_ready. mem_req is low the next cycle, Stall = 0,
//   and a following LW at 0x100 misses again.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines.
// Loads hit in zero cycles; misses and every store stall the core until the backing memory answers.
module data_cache #(
  parameter int IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RE,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [2:0]  AddressingControl,
  output logic [31:0] RD,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [1:0]  state_dbg
);

  localparam int SETS     = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              state;
  logic                ack;
  logic                just_filled;
  logic [SETS-1:0]     valid;
  logic [TAG_BITS-1:0] tags  [SETS];
  logic [31:0]         lines [SETS];

  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic [31:0]         line;
  logic                hit;
  logic                load_req;
  logic                start_write;
  logic                start_fill;

  logic [3:0]          st_strb;
  logic [31:0]         st_data;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_val;

  assign idx      = A[IDX_BITS+1:2];
  assign tag      = A[31:IDX_BITS+2];
  assign line     = lines[idx];
  assign hit      = valid[idx] && (tags[idx] == tag);
  assign load_req = RE && !WE;

  // The ack cycle lets a held store retire without reissuing it.
  assign start_write = (state == IDLE) && WE && !ack;
  assign start_fill  = (state == IDLE) && load_req && !hit;
  assign Stall       = (state != IDLE) || start_write || start_fill;
  assign state_dbg   = state;

  always_comb begin
    st_strb = 4'b1111;
    st_data = WD;
    case (AddressingControl)
      3'b000: begin
        st_strb = 4'b0001 << A[1:0];
        st_data = {4{WD[7:0]}};
      end
      3'b001: begin
        st_strb = A[1] ? 4'b1100 : 4'b0011;
        st_data = {2{WD[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = line[{A[1:0], 3'b000} +: 8];
    ld_half = A[1] ? line[31:16] : line[15:0];
    case (AddressingControl)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = line;
    endcase
    RD = ((state == IDLE) && load_req && hit) ? ld_val : 32'h0;
  end

  // Line and tag storage carries no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state == FILL) && mem_ready) begin
        lines[idx] <= mem_rdata;
        tags[idx]  <= tag;
      end else if ((state == WRITE) && mem_ready && hit) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) lines[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ack         <= 1'b0;
      just_filled <= 1'b0;
      valid       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_wstrb   <= 4'h0;
      hit_count   <= 32'h0;
      miss_count  <= 32'h0;
    end else begin
      ack         <= 1'b0;
      just_filled <= 1'b0;
      case (state)
        IDLE: begin
          if (start_write) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {A[31:2], 2'b00};
            mem_wdata <= st_data;
            mem_wstrb <= st_strb;
          end else if (start_fill) begin
            state     <= FILL;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {A[31:2], 2'b00};
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
          end else if (load_req && !just_filled && hit_count != 32'hFFFF_FFFF) begin
            hit_count <= hit_count + 32'd1;
          end
        end
        FILL: begin
          if (mem_ready) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            valid[idx]  <= 1'b1;
            just_filled <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'h0;
            ack       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed vector table, reset-mid-fill sequence and random
// load/store traffic checked against a word-level memory and tag model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [31:0] a, wd;
  logic [2:0]  ac;
  logic [31:0] rd;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] hit_count, miss_count;
  logic [1:0]  state_dbg;

  data_cache #(.IDX_BITS(6)) dut (
    .clk(clk), .rst(rst), .RE(re), .WE(we), .A(a), .WD(wd), .AddressingControl(ac),
    .RD(rd), .Stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count),
    .state_dbg(state_dbg)
  );

  // Clock: 10 time-unit period; inputs change and outputs are sampled around the falling edge.
  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic [31:0] rd;
    int          n_req;
    int          stall_cycles;
    logic        mwe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        unstable;
  } obs_t;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    int          exp_req;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: backing memory by word address plus per-set valid/tag.
  logic [31:0] ref_mem [int unsigned];
  logic        ref_valid [64];
  logic [23:0] ref_tag [64];
  int unsigned exp_hits, exp_misses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    int unsigned k;
    k = addr >> 2;
    if (ref_mem.exists(k)) return ref_mem[k];
    return (k * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (off * 8)) & 32'hFF;
    h = (w >> ((off / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] s;
    case (f3)
      3'b000:  s = 32'd1 << off;
      3'b001:  s = (off >= 2) ? 32'hC : 32'h3;
      default: s = 32'hF;
    endcase
    return s[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return (d & 32'hFF) * 32'h0101_0101;
      3'b001:  return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [3:0] strb,
                                             input logic [31:0] d);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (strb[i]) m = m | (32'hFF << (8 * i));
    return (old & ~m) | (d & m);
  endfunction

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] ad,
                              input logic [31:0] d, input logic [2:0] f3, input logic [31:0] erd,
                              input int ereq, input logic [3:0] es, input logic [31:0] ewd);
    vec_t v;
    v.we = w; v.re = r; v.a = ad; v.wd = d; v.f3 = f3;
    v.exp_rd = erd; v.exp_req = ereq; v.exp_strb = es; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // Driver: starts at a falling edge, holds the request while Stall is high and acts
  // as the backing memory with a one-cycle mem_ready after lat request cycles.
  task automatic access(input logic we_i, input logic re_i, input logic [31:0] a_i,
                        input logic [31:0] wd_i, input logic [2:0] f3_i, input int lat,
                        output obs_t obs);
    int cnt;
    logic prev_req;
    obs.done = 1'b0; obs.rd = 32'h0; obs.n_req = 0; obs.stall_cycles = 0; obs.mwe = 1'b0;
    obs.addr = 32'h0; obs.wdata = 32'h0; obs.wstrb = 4'h0; obs.unstable = 1'b0;
    we = we_i; re = re_i; a = a_i; wd = wd_i; ac = f3_i;
    cnt = 0;
    prev_req = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (!stall) begin
        obs.done = 1'b1;
        obs.rd = rd;
        obs.stall_cycles = cyc;
        break;
      end
      if (mem_req) begin
        if (!prev_req) begin
          obs.n_req++;
          obs.mwe = mem_we; obs.addr = mem_addr; obs.wdata = mem_wdata; obs.wstrb = mem_wstrb;
        end else if (mem_addr !== obs.addr || mem_wdata !== obs.wdata ||
                     mem_wstrb !== obs.wstrb || mem_we !== obs.mwe) begin
          obs.unstable = 1'b1;
        end
        cnt++;
        if (cnt == lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
        end
      end
      prev_req = mem_req;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic do_op(input logic we_i, input logic re_i, input logic [31:0] a_i,
                       input logic [31:0] wd_i, input logic [2:0] f3_i, input int lat,
                       output obs_t obs);
    int          idx;
    logic [23:0] tg;
    logic        mhit;
    logic [31:0] word;
    logic [3:0]  s;
    logic [31:0] d;
    idx  = int'(a_i[7:2]);
    tg   = a_i[31:8];
    mhit = ref_valid[idx] && (ref_tag[idx] == tg);
    word = mem_word(a_i);
    access(we_i, re_i, a_i, wd_i, f3_i, lat, obs);
    check("done", obs.done, 1);
    check("req_stable", obs.unstable, 0);
    if (we_i) begin
      s = exp_strb(f3_i, a_i[1:0]);
      d = exp_wdata(f3_i, wd_i);
      check("st_nreq", obs.n_req, 1);
      check("st_we", obs.mwe, 1);
      check("st_addr", obs.addr, a_i & 32'hFFFF_FFFC);
      check("st_strb", obs.wstrb, s);
      check("st_wdata", obs.wdata, d);
      check("st_stall", obs.stall_cycles, lat + 1);
      ref_mem[a_i >> 2] = merge_word(word, s, d);
    end else begin
      exp_q.push_back(exp_load(word, f3_i, a_i[1:0]));
      if (mhit) begin
        check("ld_hit_nreq", obs.n_req, 0);
        check("ld_hit_stall", obs.stall_cycles, 0);
        exp_hits++;
      end else begin
        check("ld_miss_nreq", obs.n_req, 1);
        check("ld_miss_we", obs.mwe, 0);
        check("ld_miss_strb", obs.wstrb, 0);
        check("ld_miss_addr", obs.addr, a_i & 32'hFFFF_FFFC);
        check("ld_miss_stall", obs.stall_cycles, lat + 1);
        ref_valid[idx] = 1'b1;
        ref_tag[idx] = tg;
        exp_misses++;
      end
      check("ld_rd", obs.rd, exp_q.pop_front());
    end
    #1;
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
    check("idle_rd", rd, 0);
    check("idle_stall", stall, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_rd", rd, 0);
    @(negedge clk);
  endtask

  vec_t vecs [15];
  obs_t ob;

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; a = 32'h0; wd = 32'h0; ac = 3'b010;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    ref_mem[32'h300 >> 2] = 32'h1122_3344;
    model_reset();

    vecs[0]  = mk(0, 1, 32'h100, 0,            3'b010, 32'hDEAD_BEEF, 1, 4'h0, 0);
    vecs[1]  = mk(0, 1, 32'h100, 0,            3'b010, 32'hDEAD_BEEF, 0, 4'h0, 0);
    vecs[2]  = mk(0, 1, 32'h103, 0,            3'b000, 32'hFFFF_FFDE, 0, 4'h0, 0);
    vecs[3]  = mk(0, 1, 32'h103, 0,            3'b100, 32'h0000_00DE, 0, 4'h0, 0);
    vecs[4]  = mk(0, 1, 32'h102, 0,            3'b001, 32'hFFFF_DEAD, 0, 4'h0, 0);
    vecs[5]  = mk(0, 1, 32'h102, 0,            3'b101, 32'h0000_DEAD, 0, 4'h0, 0);
    vecs[6]  = mk(1, 0, 32'h101, 32'h1234_565A, 3'b000, 0,            1, 4'b0010, 32'h5A5A_5A5A);
    vecs[7]  = mk(0, 1, 32'h100, 0,            3'b010, 32'hDEAD_5AEF, 0, 4'h0, 0);
    vecs[8]  = mk(1, 0, 32'h200, 32'hCAFE_F00D, 3'b010, 0,            1, 4'b1111, 32'hCAFE_F00D);
    vecs[9]  = mk(0, 1, 32'h200, 0,            3'b010, 32'hCAFE_F00D, 1, 4'h0, 0);
    vecs[10] = mk(1, 1, 32'h302, 32'hAAAA_1234, 3'b001, 0,            1, 4'b1100, 32'h1234_1234);
    vecs[11] = mk(0, 1, 32'h300, 0,            3'b010, 32'h1234_3344, 1, 4'h0, 0);
    vecs[12] = mk(1, 0, 32'h302, 32'h89AB_CDEF, 3'b101, 0,            1, 4'b1111, 32'h89AB_CDEF);
    vecs[13] = mk(0, 1, 32'h300, 0,            3'b101, 32'h0000_CDEF, 0, 4'h0, 0);
    vecs[14] = mk(0, 1, 32'h303, 0,            3'b011, 32'h89AB_CDEF, 0, 4'h0, 0);

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd, vecs[i].f3, 3, ob);
      check($sformatf("vec%0d_nreq", i), ob.n_req, vecs[i].exp_req);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_we", i), ob.mwe, 1);
        check($sformatf("vec%0d_strb", i), ob.wstrb, vecs[i].exp_strb);
        check($sformatf("vec%0d_wdata", i), ob.wdata, vecs[i].exp_wdata);
      end else begin
        check($sformatf("vec%0d_rd", i), ob.rd, vecs[i].exp_rd);
      end
    end

    // Reset in the middle of a fill abandons it and invalidates everything.
    do_op(0, 1, 32'h100, 0, 3'b010, 2, ob);
    re = 1'b1; we = 1'b0; a = 32'h204; ac = 3'b010;
    @(negedge clk);
    #1;
    check("rf_mem_req", mem_req, 1);
    check("rf_mem_addr", mem_addr, 32'h204);
    check("rf_stall", stall, 1);
    @(negedge clk);
    rst = 1'b1; re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rf_after_mem_req", mem_req, 0);
    check("rf_after_stall", stall, 0);
    check("rf_after_miss_count", miss_count, 0);
    @(negedge clk);
    do_op(0, 1, 32'h100, 0, 3'b010, 2, ob);
    check("rf_reload_miss", ob.n_req, 1);
    do_op(0, 1, 32'h204, 0, 3'b010, 1, ob);
    check("rf_abandoned_miss", ob.n_req, 1);

    // Random traffic over a small address pool so sets conflict and reuse.
    for (int i = 0; i < 300; i++) begin
      int          k;
      logic [31:0] ra;
      logic [2:0]  f3;
      k  = $urandom_range(0, 9);
      ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) ra = ra | 32'h8000_0000;
      f3 = 3'($urandom_range(0, 7));
      if (k < 2)       do_op(1, 0, ra, $urandom, f3, $urandom_range(1, 4), ob);
      else if (k == 2) do_op(1, 1, ra, $urandom, f3, $urandom_range(1, 4), ob);
      else             do_op(0, 1, ra, 0, f3, $urandom_range(1, 4), ob);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
